// File: rtl/sent_tx_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sent_tx_frame_sequencer
// Brief    : SENT fast-channel frame sequencer. It emits SYNC, STATUS, N DATA
//            nibbles and CRC symbols over a valid/done handshake. Serial
//            messages (short or enhanced) are carried on status bits 3:2.
//            Define SENT_PAUSE_EN to add the pause_req input and a PAUSE symbol.
// Revision : 1.0 - initial release
// ============================================================================
module sent_tx_frame_sequencer #(
  parameter int         MAX_NIBBLES = 6,
  parameter logic [3:0] CRC_SEED    = 4'h5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [2:0]               nibble_count,
  input  logic [4*MAX_NIBBLES-1:0] data_in,
  input  logic                     data_valid,
  output logic                     data_ack,
  input  logic [1:0]               status_lo,
  input  logic                     serial_mode,
  input  logic                     serial_valid,
  input  logic [17:0]              serial_bit2,
  input  logic [17:0]              serial_bit3,
`ifdef SENT_PAUSE_EN
  input  logic                     pause_req,
`endif
  output logic                     sym_req,
  output logic [1:0]               sym_type,
  output logic [3:0]               sym_value,
  input  logic                     sym_done,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     serial_done,
  output logic                     stale
);

  localparam logic [1:0] c_SYM_SYNC   = 2'd0;
  localparam logic [1:0] c_SYM_NIBBLE = 2'd1;
  localparam logic [1:0] c_SYM_PAUSE  = 2'd2;
  localparam logic [2:0] c_MAX_N      = 3'(MAX_NIBBLES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_STATUS = 3'd2,
    ST_DATA   = 3'd3,
`ifdef SENT_PAUSE_EN
    ST_PAUSE  = 3'd5,
`endif
    ST_CRC    = 3'd4
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [4*MAX_NIBBLES-1:0] r_data;
  logic [2:0]               r_nib_n;
  logic [2:0]               r_nib_idx;
  logic [3:0]               r_crc;
  logic [1:0]               r_status_lo;
  logic                     r_ser_mode;
  logic                     r_ser_active;
  logic [4:0]               r_ser_cnt;
  logic [17:0]              r_bit2;
  logic [17:0]              r_bit3;
  logic                     r_sym_req;
  logic [1:0]               r_sym_type;
  logic [3:0]               r_sym_value;
  logic                     r_data_ack;
  logic                     r_frame_done;
  logic                     r_serial_done;
  logic                     r_stale;
`ifdef SENT_PAUSE_EN
  logic                     r_pause;
`endif

  logic                     w_done;
  logic                     w_step;
  logic                     w_frame_end;
  logic                     w_sync_entry;
  logic                     w_ser_wrap;
  logic [4:0]               w_ser_last;
  logic [4:0]               w_ser_cnt_next;
  logic [2:0]               w_idx_next;
  logic [2:0]               w_nib_clamp;
  logic [4*MAX_NIBBLES-1:0] w_data_sh;
  logic [3:0]               w_nibble;
  logic [3:0]               w_crc_next;
  logic [3:0]               w_status;

  // Multiply by x^4 modulo x^4+x^3+x^2+1.
  function automatic logic [3:0] crc_step(input logic [3:0] v);
    logic [3:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      r = {r[2:0], 1'b0} ^ (r[3] ? 4'hD : 4'h0);
    end
    return r;
  endfunction

  always_comb begin
    w_done       = sym_done && r_sym_req;
    w_state_next = r_state;
    w_frame_end  = 1'b0;
    case (r_state)
      ST_IDLE:   if (enable) w_state_next = ST_SYNC;
      ST_SYNC:   if (w_done) w_state_next = ST_STATUS;
      ST_STATUS: if (w_done) w_state_next = ST_DATA;
      ST_DATA:   if (w_done && (r_nib_idx == r_nib_n - 3'd1)) w_state_next = ST_CRC;
      ST_CRC: begin
        if (w_done) begin
`ifdef SENT_PAUSE_EN
          if (r_pause) w_state_next = ST_PAUSE;
          else         w_frame_end  = 1'b1;
`else
          w_frame_end = 1'b1;
`endif
        end
      end
`ifdef SENT_PAUSE_EN
      ST_PAUSE:  if (w_done) w_frame_end = 1'b1;
`endif
      default:   w_state_next = ST_IDLE;
    endcase
    if (w_frame_end) w_state_next = enable ? ST_SYNC : ST_IDLE;

    w_step       = w_done || ((r_state == ST_IDLE) && enable);
    w_sync_entry = (w_state_next == ST_SYNC) && ((r_state == ST_IDLE) || w_frame_end);

    w_ser_last     = r_ser_mode ? 5'd17 : 5'd15;
    w_ser_wrap     = w_frame_end && r_ser_active && (r_ser_cnt == w_ser_last);
    w_ser_cnt_next = r_ser_cnt;
    if (w_frame_end) begin
      if (!r_ser_active || w_ser_wrap) w_ser_cnt_next = 5'd0;
      else                             w_ser_cnt_next = r_ser_cnt + 5'd1;
    end

    w_nib_clamp = ((nibble_count == 3'd0) || (nibble_count > c_MAX_N)) ? c_MAX_N : nibble_count;
    w_idx_next  = (r_state == ST_DATA) ? r_nib_idx + 3'd1 : 3'd0;
    w_data_sh   = r_data << {w_idx_next, 2'b00};
    w_nibble    = w_data_sh[4*MAX_NIBBLES-1 -: 4];
    // The nibble just acknowledged is still held in r_sym_value.
    w_crc_next  = crc_step(r_crc) ^ r_sym_value;
    w_status    = {r_ser_active && (r_ser_mode ? r_bit3[17] : (r_ser_cnt == 5'd0)),
                   r_ser_active && r_bit2[17],
                   r_status_lo};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_data        <= '0;
      r_nib_n       <= 3'd0;
      r_nib_idx     <= 3'd0;
      r_crc         <= 4'd0;
      r_status_lo   <= 2'd0;
      r_ser_mode    <= 1'b0;
      r_ser_active  <= 1'b0;
      r_ser_cnt     <= 5'd0;
      r_bit2        <= 18'd0;
      r_bit3        <= 18'd0;
      r_sym_req     <= 1'b0;
      r_sym_type    <= c_SYM_SYNC;
      r_sym_value   <= 4'd0;
      r_data_ack    <= 1'b0;
      r_frame_done  <= 1'b0;
      r_serial_done <= 1'b0;
      r_stale       <= 1'b0;
`ifdef SENT_PAUSE_EN
      r_pause       <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_next;
      r_data_ack    <= 1'b0;
      r_frame_done  <= w_frame_end;
      r_serial_done <= w_ser_wrap;
      r_ser_cnt     <= w_ser_cnt_next;

      if (w_sync_entry) begin
        if (data_valid) begin
          r_data     <= data_in;
          r_data_ack <= 1'b1;
          r_stale    <= 1'b0;
        end else begin
          r_stale    <= 1'b1;
        end
        r_nib_n     <= w_nib_clamp;
        r_crc       <= CRC_SEED;
        r_status_lo <= status_lo;
        // Serial words are only taken at the start of a message.
        if (w_ser_cnt_next == 5'd0) begin
          r_ser_mode   <= serial_mode;
          r_ser_active <= serial_valid;
          if (serial_valid) begin
            r_bit2 <= serial_mode ? serial_bit2 : {serial_bit2[15:0], 2'b00};
            r_bit3 <= serial_bit3;
          end else begin
            r_bit2 <= 18'd0;
            r_bit3 <= 18'd0;
          end
        end
      end

      if ((r_state == ST_STATUS) && w_done) begin
        r_bit2 <= {r_bit2[16:0], 1'b0};
        r_bit3 <= {r_bit3[16:0], 1'b0};
      end
      if (w_done && ((r_state == ST_STATUS) || (r_state == ST_DATA))) r_nib_idx <= w_idx_next;
      if ((r_state == ST_DATA) && w_done) r_crc <= w_crc_next;
`ifdef SENT_PAUSE_EN
      if ((r_state == ST_DATA) && (w_state_next == ST_CRC)) r_pause <= pause_req;
`endif

      if (w_step) begin
        r_sym_req   <= 1'b1;
        r_sym_type  <= c_SYM_NIBBLE;
        r_sym_value <= 4'd0;
        case (w_state_next)
          ST_SYNC:   r_sym_type  <= c_SYM_SYNC;
          ST_STATUS: r_sym_value <= w_status;
          ST_DATA:   r_sym_value <= w_nibble;
          ST_CRC:    r_sym_value <= crc_step(w_crc_next);
`ifdef SENT_PAUSE_EN
          ST_PAUSE:  r_sym_type  <= c_SYM_PAUSE;
`endif
          default: begin
            r_sym_req  <= 1'b0;
            r_sym_type <= c_SYM_SYNC;
          end
        endcase
      end
    end
  end

  assign sym_req     = r_sym_req;
  assign sym_type    = r_sym_type;
  assign sym_value   = r_sym_value;
  assign data_ack    = r_data_ack;
  assign frame_done  = r_frame_done;
  assign serial_done = r_serial_done;
  assign stale       = r_stale;
  assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire
